// File: rtl/shift_serdes_if.sv
// rtl/shift_serdes_if.sv - handshake bundle between shift_serdes and its serial/parallel neighbours
interface shift_serdes_if #(
  parameter int WIDTH  = 8,
  parameter int LANE_W = 1
);
  logic              abort;
  logic              mode;
  logic [LANE_W-1:0] s_in;
  logic              s_in_valid;
  logic              s_in_ready;
  logic [WIDTH-1:0]  p_out;
  logic              p_out_valid;
  logic              p_out_ready;
  logic [WIDTH-1:0]  p_in;
  logic              p_in_valid;
  logic              p_in_ready;
  logic [LANE_W-1:0] s_out;
  logic              s_out_valid;
  logic              s_out_ready;
  logic              busy;
  logic              word_done;

  modport slave (
    input  abort, mode, s_in, s_in_valid, p_out_ready, p_in, p_in_valid, s_out_ready,
    output s_in_ready, p_out, p_out_valid, p_in_ready, s_out, s_out_valid, busy, word_done
  );

  modport master (
    output abort, mode, s_in, s_in_valid, p_out_ready, p_in, p_in_valid, s_out_ready,
    input  s_in_ready, p_out, p_out_valid, p_in_ready, s_out, s_out_valid, busy, word_done
  );
endinterface

// File: rtl/shift_serdes.sv
// rtl/shift_serdes.sv - LANE_W-bit serial <-> WIDTH-bit parallel converter, direction chosen per word
module shift_serdes #(
  parameter int WIDTH     = 8,
  parameter int LANE_W    = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic          clk,
  input  logic          reset,
  shift_serdes_if.slave bus
);
  localparam int            BEATS = WIDTH / LANE_W;
  localparam int            CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST  = CW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, DESER, DHOLD, SER} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  shadow_q, shadow_d;
  logic [WIDTH-1:0]  p_out_q, p_out_d;
  logic [LANE_W-1:0] s_out_q, s_out_d;
  logic              done_q, done_d;
  logic              s_in_ready, p_in_ready, p_out_valid, s_out_valid;
  logic              s_xfer, p_xfer, o_xfer;

  // MSB_FIRST only reorders slots; bits inside a lane keep their order
  function automatic int slot_lsb(input int beat);
    return ((MSB_FIRST != 0) ? (BEATS - 1 - beat) : beat) * LANE_W;
  endfunction

  assign s_xfer = bus.s_in_valid && s_in_ready;
  assign p_xfer = bus.p_in_valid && p_in_ready;
  assign o_xfer = s_out_valid && bus.s_out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      shadow_q <= '0;
      p_out_q  <= '0;
      s_out_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      shadow_q <= shadow_d;
      p_out_q  <= p_out_d;
      s_out_q  <= s_out_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    shadow_d = shadow_q;
    p_out_d  = p_out_q;
    s_out_d  = s_out_q;
    done_d   = 1'b0;
    if (bus.abort) begin
      // abort beats every handshake, including a coincident last beat
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_xfer) begin
            acc_d[slot_lsb(0) +: LANE_W] = bus.s_in;
            if (BEATS == 1) begin
              p_out_d = acc_d;
              done_d  = 1'b1;
              state_d = DHOLD;
            end else begin
              cnt_d   = CW'(1);
              state_d = DESER;
            end
          end else if (p_xfer) begin
            shadow_d = bus.p_in;
            s_out_d  = bus.p_in[slot_lsb(0) +: LANE_W];
            cnt_d    = '0;
            state_d  = SER;
          end
        end
        DESER: begin
          if (s_xfer) begin
            acc_d[slot_lsb(int'(cnt_q)) +: LANE_W] = bus.s_in;
            if (cnt_q == LAST) begin
              p_out_d = acc_d;
              done_d  = 1'b1;
              cnt_d   = '0;
              state_d = DHOLD;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        DHOLD: begin
          if (bus.p_out_ready) state_d = IDLE;
        end
        SER: begin
          if (o_xfer) begin
            if (cnt_q == LAST) begin
              cnt_d   = '0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              cnt_d   = cnt_q + CW'(1);
              s_out_d = shadow_q[slot_lsb(int'(cnt_q) + 1) +: LANE_W];
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // readies are gated by reset so every output reads 0 while reset is held
  always_comb begin
    s_in_ready  = 1'b0;
    p_in_ready  = 1'b0;
    p_out_valid = (state_q == DHOLD);
    s_out_valid = (state_q == SER);
    if (!reset) begin
      case (state_q)
        IDLE: begin
          s_in_ready = !bus.mode;
          p_in_ready = bus.mode;
        end
        DESER:   s_in_ready = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.s_in_ready  = s_in_ready;
  assign bus.p_in_ready  = p_in_ready;
  assign bus.p_out_valid = p_out_valid;
  assign bus.s_out_valid = s_out_valid;
  assign bus.p_out       = p_out_q;
  assign bus.s_out       = s_out_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.word_done   = done_q;
endmodule

// File: tb/tb_shift_serdes.sv
// tb/tb_shift_serdes.sv - self-checking bench for shift_serdes across five parameter sets
module tb_shift_serdes;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  shift_serdes_if #(.WIDTH(8),  .LANE_W(1)) ia ();
  shift_serdes_if #(.WIDTH(8),  .LANE_W(1)) ib ();
  shift_serdes_if #(.WIDTH(16), .LANE_W(4)) ic ();
  shift_serdes_if #(.WIDTH(8),  .LANE_W(2)) id ();
  shift_serdes_if #(.WIDTH(8),  .LANE_W(8)) ie ();

  shift_serdes #(.WIDTH(8),  .LANE_W(1), .MSB_FIRST(0)) ua (.clk(clk), .reset(reset), .bus(ia.slave));
  shift_serdes #(.WIDTH(8),  .LANE_W(1), .MSB_FIRST(1)) ub (.clk(clk), .reset(reset), .bus(ib.slave));
  shift_serdes #(.WIDTH(16), .LANE_W(4), .MSB_FIRST(0)) uc (.clk(clk), .reset(reset), .bus(ic.slave));
  shift_serdes #(.WIDTH(8),  .LANE_W(2), .MSB_FIRST(0)) ud (.clk(clk), .reset(reset), .bus(id.slave));
  shift_serdes #(.WIDTH(8),  .LANE_W(8), .MSB_FIRST(0)) ue (.clk(clk), .reset(reset), .bus(ie.slave));

  int total = 0;
  int bad = 0;
  logic [31:0] qa[$], qb[$], qc[$], qd[$], qe[$];

  typedef struct {
    logic s_in;
    logic vld;
    logic prdy;
    logic e_srdy;
    logic e_pov;
    logic e_wd;
    logic e_busy;
  } vec_t;
  vec_t tv[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic extra(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got output %0h, want none", name, act);
  endtask

  // scoreboard: expected words/beats are queued when stimulus is driven, popped on each output transfer
  always @(negedge clk) begin
    #3;
    if (ia.p_out_valid && ia.p_out_ready) begin
      if (qa.size() == 0) extra("a_pout_extra", ia.p_out); else check("a_pout", ia.p_out, qa.pop_front());
    end
    if (ib.p_out_valid && ib.p_out_ready) begin
      if (qb.size() == 0) extra("b_pout_extra", ib.p_out); else check("b_pout", ib.p_out, qb.pop_front());
    end
    if (ic.s_out_valid && ic.s_out_ready) begin
      if (qc.size() == 0) extra("c_sout_extra", ic.s_out); else check("c_sout", ic.s_out, qc.pop_front());
    end
    if (id.p_out_valid && id.p_out_ready) begin
      if (qd.size() == 0) extra("d_pout_extra", id.p_out); else check("d_pout", id.p_out, qd.pop_front());
    end
    if (ie.p_out_valid && ie.p_out_ready) begin
      if (qe.size() == 0) extra("e_pout_extra", ie.p_out); else check("e_pout", ie.p_out, qe.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  bits;
    logic [1:0]  dbeats[4];
    logic [3:0]  prev;
    logic        prev_stall;
    int          n, cyc;

    bits = 8'b0100_1101;
    dbeats[0] = 2'b01; dbeats[1] = 2'b10; dbeats[2] = 2'b11; dbeats[3] = 2'b00;
    for (int i = 0; i < 8; i++)
      tv[i] = '{bits[i], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, (i != 0)};
    tv[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tv[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    ia.abort = 0; ia.mode = 0; ia.s_in = '0; ia.s_in_valid = 0; ia.p_out_ready = 0; ia.p_in = '0; ia.p_in_valid = 0; ia.s_out_ready = 0;
    ib.abort = 0; ib.mode = 0; ib.s_in = '0; ib.s_in_valid = 0; ib.p_out_ready = 0; ib.p_in = '0; ib.p_in_valid = 0; ib.s_out_ready = 0;
    ic.abort = 0; ic.mode = 1; ic.s_in = '0; ic.s_in_valid = 0; ic.p_out_ready = 0; ic.p_in = '0; ic.p_in_valid = 0; ic.s_out_ready = 0;
    id.abort = 0; id.mode = 0; id.s_in = '0; id.s_in_valid = 0; id.p_out_ready = 0; id.p_in = '0; id.p_in_valid = 0; id.s_out_ready = 0;
    ie.abort = 0; ie.mode = 0; ie.s_in = '0; ie.s_in_valid = 0; ie.p_out_ready = 0; ie.p_in = '0; ie.p_in_valid = 0; ie.s_out_ready = 0;

    // reset state
    #1;
    check("rst_a_pout", ia.p_out, 0);
    check("rst_a_srdy", ia.s_in_ready, 0);
    check("rst_a_pov", ia.p_out_valid, 0);
    check("rst_a_busy", ia.busy, 0);
    check("rst_a_wd", ia.word_done, 0);
    check("rst_c_prdy", ic.p_in_ready, 0);
    check("rst_c_sov", ic.s_out_valid, 0);
    check("rst_c_sout", ic.s_out, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_a_srdy", ia.s_in_ready, 1);
    check("post_rst_c_prdy", ic.p_in_ready, 1);

    // test 1: LSB-first 1-bit deserializer, table-driven
    qa.push_back(32'h4D);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      ia.s_in = tv[i].s_in; ia.s_in_valid = tv[i].vld; ia.p_out_ready = tv[i].prdy;
      #1;
      check($sformatf("a_srdy[%0d]", i), ia.s_in_ready, tv[i].e_srdy);
      check($sformatf("a_pov[%0d]", i),  ia.p_out_valid, tv[i].e_pov);
      check($sformatf("a_wd[%0d]", i),   ia.word_done, tv[i].e_wd);
      check($sformatf("a_busy[%0d]", i), ia.busy, tv[i].e_busy);
    end

    // test 2: MSB-first, consumer stalls for 5 cycles
    qb.push_back(32'hB2);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ib.s_in = bits[i]; ib.s_in_valid = 1;
    end
    @(negedge clk);
    ib.s_in_valid = 0; ib.s_in = 1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      ib.s_in_valid = (k >= 2);
      #1;
      check($sformatf("b_hold_srdy[%0d]", k), ib.s_in_ready, 0);
      check($sformatf("b_hold_pov[%0d]", k), ib.p_out_valid, 1);
      check($sformatf("b_hold_pout[%0d]", k), ib.p_out, 32'hB2);
    end
    @(negedge clk);
    ib.s_in_valid = 0; ib.p_out_ready = 1;
    @(negedge clk);
    ib.p_out_ready = 0;
    #1;
    check("b_after_pov", ib.p_out_valid, 0);
    check("b_after_pout_kept", ib.p_out, 32'hB2);

    // test 3: 16-bit word out as 4-bit lanes with a toggling sink
    qc.push_back(4'h3); qc.push_back(4'hC); qc.push_back(4'h5); qc.push_back(4'hA);
    @(negedge clk);
    ic.p_in = 16'hA5C3; ic.p_in_valid = 1;
    #1;
    check("c_idle_prdy", ic.p_in_ready, 1);
    @(negedge clk);
    ic.p_in_valid = 0;
    #1;
    check("c_ser_sov", ic.s_out_valid, 1);
    check("c_ser_prdy", ic.p_in_ready, 0);
    n = 0; cyc = 0; prev = '0; prev_stall = 0;
    while (n < 4 && cyc < 40) begin
      if (cyc > 0) @(negedge clk);
      ic.s_out_ready = (cyc % 2 == 0);
      #1;
      if (prev_stall) check($sformatf("c_stall_stable[%0d]", cyc), ic.s_out, prev);
      check($sformatf("c_mid_wd[%0d]", cyc), ic.word_done, 0);
      prev_stall = !ic.s_out_ready;
      if (ic.s_out_valid && ic.s_out_ready) n++;
      prev = ic.s_out;
      cyc++;
    end
    check("c_beats_before_budget", n, 4);
    @(negedge clk);
    ic.s_out_ready = 0;
    #1;
    check("c_done_wd", ic.word_done, 1);
    check("c_done_prdy", ic.p_in_ready, 1);
    check("c_done_sov", ic.s_out_valid, 0);
    @(negedge clk);
    #1;
    check("c_wd_one_pulse", ic.word_done, 0);

    // test 4: 2-bit lanes, gapped beats then abort, then a fresh word
    @(negedge clk);
    id.s_in = 2'b11; id.s_in_valid = 1;
    @(negedge clk);
    id.s_in_valid = 0;
    #1;
    check("d_busy_gap", id.busy, 1);
    @(negedge clk);
    @(negedge clk);
    id.s_in = 2'b10; id.s_in_valid = 1;
    @(negedge clk);
    id.s_in_valid = 0;
    @(negedge clk);
    id.abort = 1;
    #1;
    check("d_pre_abort_busy", id.busy, 1);
    @(negedge clk);
    id.abort = 0;
    #1;
    check("d_abort_busy", id.busy, 0);
    check("d_abort_pov", id.p_out_valid, 0);
    check("d_abort_wd", id.word_done, 0);
    check("d_abort_srdy", id.s_in_ready, 1);
    qd.push_back(32'h39);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      id.s_in = dbeats[i]; id.s_in_valid = 1;
      #1;
      check($sformatf("d_beat_srdy[%0d]", i), id.s_in_ready, 1);
    end
    @(negedge clk);
    id.s_in_valid = 0; id.p_out_ready = 1;
    #1;
    check("d_done_pov", id.p_out_valid, 1);
    check("d_done_wd", id.word_done, 1);
    @(negedge clk);
    id.p_out_ready = 0;
    #1;
    check("d_idle_pov", id.p_out_valid, 0);
    // abort coinciding with the last beat discards the word
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      id.s_in = ~dbeats[i]; id.s_in_valid = 1; id.abort = (i == 3);
    end
    @(negedge clk);
    id.s_in_valid = 0; id.abort = 0;
    #1;
    check("d_lastabort_pov", id.p_out_valid, 0);
    check("d_lastabort_wd", id.word_done, 0);
    check("d_lastabort_busy", id.busy, 0);
    check("d_lastabort_pout", id.p_out, 32'h39);

    // test 6: single-beat word, mode toggled while holding
    qe.push_back(32'h7E);
    @(negedge clk);
    ie.s_in = 8'h7E; ie.s_in_valid = 1;
    #1;
    check("e_idle_srdy", ie.s_in_ready, 1);
    @(negedge clk);
    ie.s_in_valid = 0; ie.mode = 1;
    #1;
    check("e_hold_pov", ie.p_out_valid, 1);
    check("e_hold_pout", ie.p_out, 32'h7E);
    check("e_hold_wd", ie.word_done, 1);
    check("e_hold_prdy", ie.p_in_ready, 0);
    @(negedge clk);
    ie.mode = 0;
    #1;
    check("e_hold_pov2", ie.p_out_valid, 1);
    check("e_hold_srdy2", ie.s_in_ready, 0);
    @(negedge clk);
    ie.mode = 1; ie.p_out_ready = 1;
    @(negedge clk);
    ie.p_out_ready = 0;
    #1;
    check("e_idle_pov", ie.p_out_valid, 0);
    check("e_idle_prdy_mode1", ie.p_in_ready, 1);
    ie.mode = 0;

    // test 5: asynchronous reset in the middle of a serialization
    @(negedge clk);
    ic.p_in = 16'h1234; ic.p_in_valid = 1; ic.s_out_ready = 0;
    @(negedge clk);
    ic.p_in_valid = 0;
    #1;
    check("c5_ser_sov", ic.s_out_valid, 1);
    check("c5_ser_sout", ic.s_out, 4'h4);
    #1;
    reset = 1'b1;
    #1;
    check("c5_rst_sout", ic.s_out, 0);
    check("c5_rst_sov", ic.s_out_valid, 0);
    check("c5_rst_prdy", ic.p_in_ready, 0);
    check("c5_rst_busy", ic.busy, 0);
    check("c5_rst_wd", ic.word_done, 0);
    check("c5_rst_a_pout", ia.p_out, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("c5_post_prdy", ic.p_in_ready, 1);
    check("c5_post_busy", ic.busy, 0);

    repeat (2) @(negedge clk);
    check("qa_empty", qa.size(), 0);
    check("qb_empty", qb.size(), 0);
    check("qc_empty", qc.size(), 0);
    check("qd_empty", qd.size(), 0);
    check("qe_empty", qe.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_serdes.md
Name: shift_serdes

Overview:
Parametrised serializer/deserializer that succeeds the single-bit SIPO. The block moves data between a LANE_W-bit serial stream and a WIDTH-bit parallel word in either direction, selected per word by `mode`. Slot order is configurable. Both sides use valid/ready handshakes. It sits between bit-serial peripherals (UART/SPI-style front ends) and the word-wide CPU datapath.

Parameters:
- WIDTH, 8, parallel word width; must be a multiple of LANE_W.
- LANE_W, 1, serial bits per beat; 1 <= LANE_W <= WIDTH.
- MSB_FIRST, 0, 0: beat k maps to bits [k*LANE_W +: LANE_W]; 1: beat k maps to bits [(BEATS-1-k)*LANE_W +: LANE_W].

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- abort  input  1  synchronous clear of the current transfer
- mode  input  1  0 = deserialize, 1 = serialize; sampled only in IDLE
- s_in  input  LANE_W  serial input beat
- s_in_valid  input  1  s_in beat present
- s_in_ready  output  1  deserializer accepts a beat
- p_out  output  WIDTH  assembled parallel word
- p_out_valid  output  1  p_out holds a completed word
- p_out_ready  input  1  consumer takes p_out
- p_in  input  WIDTH  parallel word to serialize
- p_in_valid  input  1  p_in present
- p_in_ready  output  1  serializer accepts a word
- s_out  output  LANE_W  serial output beat
- s_out_valid  output  1  s_out beat present
- s_out_ready  input  1  sink takes s_out
- busy  output  1  state != IDLE
- word_done  output  1  one-cycle completion pulse

Behaviour:
- Derived values: BEATS = WIDTH/LANE_W. Beat counter width = max(1, $clog2(BEATS)).
- Reset (async): state IDLE, counter 0, accumulator 0, shadow 0. All outputs 0: p_out, s_out, every valid/ready output, busy, word_done.
- States: IDLE, DESER, DHOLD, SER.
- Lane bits keep their order inside a slot. MSB_FIRST affects only slot selection.
- A transfer occurs on a cycle where valid and ready are both 1 at the rising edge.
- IDLE:
  - s_in_ready = (mode == 0); p_in_ready = (mode == 1).
  - mode 0 with an s_in transfer: beat 0 is written to its slot, counter = 1. Next state is DESER, or DHOLD if BEATS == 1.
  - mode 1 with a p_in transfer: p_in is loaded into the shadow register, counter = 0, next state SER.
- DESER:
  - s_in_ready = 1.
  - Each transfer writes beat[counter] into the accumulator and increments the counter.
  - On the transfer with counter == BEATS-1: accumulator (including this beat) is copied to p_out, word_done pulses, next state DHOLD.
  - Cycles with s_in_valid = 0 hold state. Gaps are allowed and there is no timeout.
- DHOLD:
  - p_out_valid = 1; s_in_ready = 0, so incoming beats stall upstream.
  - p_out stays stable until the p_out transfer.
  - On the p_out transfer, next state is IDLE with p_out_valid = 0 next cycle. p_out keeps its value afterwards.
- SER:
  - s_out_valid = 1 and s_out = shadow slot[counter]. s_out is registered and stable while stalled.
  - On each s_out transfer the counter increments.
  - On the transfer of beat BEATS-1: word_done pulses, next state IDLE.
  - p_in_ready = 0 throughout SER.
- Throughput:
  - Deserializer latency: p_out_valid asserts the cycle after the last beat transfer.
  - Serializer: first s_out_valid appears the cycle after the p_in transfer.
  - Each word costs BEATS + 1 cycles minimum, because one IDLE cycle separates words.
- mode changes outside IDLE are ignored.
- abort (priority over all handshakes):
  - Next state IDLE, counter 0, accumulator 0.
  - Valid outputs deassert next cycle; word_done is not pulsed.
  - p_out keeps its last completed word.
- Simultaneous abort and last-beat transfer: abort wins; the word is discarded.
- Counter wraps to 0 only through completion or abort. It never exceeds BEATS-1.
- reset asserted mid-transfer: immediate return to reset values, independent of clk.

Test Plan:
1. WIDTH=8, LANE_W=1, MSB_FIRST=0, mode=0; send bits 1,0,1,1,0,0,1,0 back-to-back -> p_out=8'h4D, p_out_valid 1 cycle after the 8th beat, word_done one pulse.
2. Same stream with MSB_FIRST=1 -> p_out=8'hB2. Hold p_out_ready=0 for 5 cycles -> s_in_ready=0 and p_out stable throughout.
3. WIDTH=16, LANE_W=4, MSB_FIRST=0, mode=1; p_in=16'hA5C3, s_out_ready toggling 1,0,1,... -> s_out sequence 3,C,5,A, each stable while stalled. word_done on the 4th transfer; p_in_ready returns 1 the cycle after.
4. WIDTH=8, LANE_W=2, mode=0; 2 beats with idle gaps, then abort -> IDLE next cycle, no p_out_valid, no word_done. Fresh 4 beats 2'b01,2'b10,2'b11,2'b00 -> p_out=8'h39.
5. Async reset asserted mid-SER between clock edges -> all outputs 0 immediately. After release, IDLE with p_in_ready=1 when mode=1.
6. WIDTH=8, LANE_W=8 (BEATS=1), mode=0; one beat 8'h7E -> DHOLD next cycle with p_out=8'h7E. mode toggled during DHOLD has no effect.
